// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the per-stage hold polarity.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int FCNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_stall_mask.sv
// Turns one stall request into a per-stage hold mask.
// The requesting stage and every stage upstream of it are held.
module pipe_ctrl_stall_mask
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6
) (
  input  logic [3:0]            stage,
  input  logic                  req,
  output logic [NUM_STAGES-1:0] mask
);

  always_comb begin
    mask = {NUM_STAGES{NO_STOP}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (req && (i <= int'(stage))) begin
        mask[i] = STOP;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stalls, timed flush window with
// redirect target, and a saturating stall-length counter with sticky timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                   NUM_STAGES    = 6,
  parameter int                   NUM_REQ       = 2,
  parameter logic [4*NUM_REQ-1:0] REQ_STAGE     = {4'd3, 4'd2},
  parameter int                   AW            = 32,
  parameter int                   FLUSH_CYCLES  = 1,
  parameter int                   CW            = 8,
  parameter int                   STALL_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stallreq,
  input  logic                  flush_req,
  input  logic [AW-1:0]         flush_pc,
  input  logic                  clr_timeout,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [AW-1:0]         new_pc,
  output logic [CW-1:0]         stall_cycles,
  output logic                  stall_timeout
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD  = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0]     TIMEOUT_VAL = CW'(STALL_TIMEOUT);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]       new_pc_q, new_pc_d;
  logic [CW-1:0]       stall_cycles_q, stall_cycles_d;
  logic                stall_timeout_q, stall_timeout_d;

  logic [NUM_STAGES-1:0] req_mask [NUM_REQ];
  logic [NUM_STAGES-1:0] mask_or;
  logic                  req_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
    pipe_ctrl_stall_mask #(
      .NUM_STAGES(NUM_STAGES)
    ) u_mask (
      .stage(REQ_STAGE[4*g +: 4]),
      .req  (stallreq[g]),
      .mask (req_mask[g])
    );
  end

  always_comb begin
    mask_or = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_or = mask_or | req_mask[i];
    end
  end

  assign req_any = |stallreq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RUN;
      flush_cnt_q     <= '0;
      new_pc_q        <= '0;
      stall_cycles_q  <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      new_pc_q        <= new_pc_d;
      stall_cycles_q  <= stall_cycles_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // A flush request overrides everything, including an open flush window.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    if (flush_req) begin
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
      new_pc_d    = flush_pc;
    end else begin
      case (state_q)
        RUN:   if (req_any) state_d = STALL;
        STALL: if (!req_any) state_d = RUN;
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = req_any ? STALL : RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_d != STALL) begin
      stall_cycles_d = '0;
    end else if ((state_q == STALL) && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    stall_timeout_d = stall_timeout_q;
    if ((stall_cycles_d == TIMEOUT_VAL) && (stall_cycles_q != TIMEOUT_VAL)) begin
      stall_timeout_d = 1'b1;
    end else if (clr_timeout) begin
      stall_timeout_d = 1'b0;
    end
  end

  // Holds are gated by reset so no stage freezes while the core is in reset.
  always_comb begin
    stall = '0;
    flush = 1'b0;
    if (state_q == FLUSH) begin
      flush = 1'b1;
    end else if (rst) begin
      stall = mask_or;
    end
  end

  assign new_pc        = new_pc_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; four instances share stimulus so that the
// default, long-flush and short-counter configurations are exercised together.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        clr_timeout;

  logic [5:0]  stall0, stall3, stall4, stallt;
  logic        flush0, flush3, flush4, flusht;
  logic [31:0] new_pc0, new_pc3, new_pc4, new_pct;
  logic [7:0]  cycles0, cycles3, cycles4;
  logic [2:0]  cyclest;
  logic        timeout0, timeout3, timeout4, timeoutt;

  int n_compared = 0;
  int n_mismatched = 0;

  pipe_ctrl dut0 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_timeout(clr_timeout), .stall(stall0),
    .flush(flush0), .new_pc(new_pc0), .stall_cycles(cycles0),
    .stall_timeout(timeout0)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_timeout(clr_timeout), .stall(stall3),
    .flush(flush3), .new_pc(new_pc3), .stall_cycles(cycles3),
    .stall_timeout(timeout3)
  );

  pipe_ctrl #(.FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_timeout(clr_timeout), .stall(stall4),
    .flush(flush4), .new_pc(new_pc4), .stall_cycles(cycles4),
    .stall_timeout(timeout4)
  );

  pipe_ctrl #(.CW(3), .STALL_TIMEOUT(5)) dutt (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_timeout(clr_timeout), .stall(stallt),
    .flush(flusht), .new_pc(new_pct), .stall_cycles(cyclest),
    .stall_timeout(timeoutt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sr, input logic fr,
                               input logic [31:0] pc, input logic clr);
    stallreq    = sr;
    flush_req   = fr;
    flush_pc    = pc;
    clr_timeout = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b0);
    repeat (n) stepCycle();
  endtask

  initial begin
    int exp_cyc [4];
    exp_cyc = '{0, 0, 1, 2};

    rst = 1'b0;
    applyStimulus(2'b11, 1'b0, 32'h0, 1'b0);
    repeat (2) waitSample();
    checkOutput("rst_stall", 32'(stall0), 32'h0);
    checkOutput("rst_flush", 32'(flush0), 32'h0);
    checkOutput("rst_new_pc", new_pc0, 32'h0);
    checkOutput("rst_cycles", 32'(cycles0), 32'h0);
    checkOutput("rst_timeout", 32'(timeout0), 32'h0);
    stepCycle();
    rst = 1'b1;
    idle(1);

    // ID request held through three stalled edges, then released
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitSample();
      checkOutput($sformatf("id_stall_c%0d", k), 32'(stall0), 32'h07);
      checkOutput($sformatf("id_cycles_c%0d", k), 32'(cycles0), 32'(exp_cyc[k]));
      stepCycle();
    end
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b0);
    waitSample();
    checkOutput("release_stall", 32'(stall0), 32'h0);
    checkOutput("release_cycles3", 32'(cycles0), 32'd3);
    stepCycle();
    waitSample();
    checkOutput("release_cycles0", 32'(cycles0), 32'd0);
    stepCycle();

    // EX request, then flush on the same edge as both requests
    applyStimulus(2'b10, 1'b0, 32'h0, 1'b0);
    waitSample();
    checkOutput("ex_stall", 32'(stall0), 32'h0f);
    stepCycle();
    applyStimulus(2'b11, 1'b1, 32'h100, 1'b0);
    waitSample();
    checkOutput("both_stall", 32'(stall0), 32'h0f);
    stepCycle();
    applyStimulus(2'b11, 1'b0, 32'h0, 1'b0);
    waitSample();
    checkOutput("flush_on", 32'(flush0), 32'h1);
    checkOutput("flush_stall0", 32'(stall0), 32'h0);
    checkOutput("flush_new_pc", new_pc0, 32'h100);
    checkOutput("flush_cycles", 32'(cycles0), 32'h0);
    stepCycle();
    waitSample();
    checkOutput("post_flush_off", 32'(flush0), 32'h0);
    checkOutput("post_flush_stall", 32'(stall0), 32'h0f);
    stepCycle();
    idle(6);

    // Three-cycle window re-armed from its second cycle
    applyStimulus(2'b00, 1'b1, 32'h40, 1'b0);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b0);
    waitSample();
    checkOutput("f3_c1_flush", 32'(flush3), 32'h1);
    checkOutput("f3_c1_pc", new_pc3, 32'h40);
    checkOutput("f1_c1_flush", 32'(flush0), 32'h1);
    stepCycle();
    applyStimulus(2'b00, 1'b1, 32'h80, 1'b0);
    waitSample();
    checkOutput("f3_c2_flush", 32'(flush3), 32'h1);
    checkOutput("f3_c2_pc", new_pc3, 32'h40);
    checkOutput("f1_c2_flush", 32'(flush0), 32'h0);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitSample();
      checkOutput($sformatf("f3_rearm_flush%0d", k), 32'(flush3), 32'h1);
      checkOutput($sformatf("f3_rearm_pc%0d", k), new_pc3, 32'h80);
      stepCycle();
    end
    waitSample();
    checkOutput("f3_end_flush", 32'(flush3), 32'h0);
    checkOutput("f3_end_pc_hold", new_pc3, 32'h80);
    stepCycle();
    idle(6);

    // Long stall against a 3-bit counter with timeout at 5
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b0);
    stepCycle();
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      waitSample();
      checkOutput($sformatf("to_cycles_e%0d", k), 32'(cyclest), (k > 7) ? 32'd7 : 32'(k));
      checkOutput($sformatf("to_flag_e%0d", k), 32'(timeoutt), (k >= 5) ? 32'd1 : 32'd0);
    end
    checkOutput("wide_cycles_e10", 32'(cycles0), 32'd10);
    checkOutput("wide_timeout", 32'(timeout0), 32'd0);
    stepCycle();
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b1);
    waitSample();
    checkOutput("to_sticky", 32'(timeoutt), 32'd1);
    stepCycle();
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b0);
    waitSample();
    checkOutput("to_cleared", 32'(timeoutt), 32'd0);
    checkOutput("to_sat_hold", 32'(cyclest), 32'd7);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b1);
    stepCycle();
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b1);
    stepCycle();
    for (int k = 1; k <= 6; k++) begin
      stepCycle();
      waitSample();
      checkOutput($sformatf("setwin_flag_e%0d", k), 32'(timeoutt), (k == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("setwin_cycles_e%0d", k), 32'(cyclest), 32'(k));
    end
    stepCycle();
    idle(3);

    // Reset during the first cycle of a four-cycle flush
    applyStimulus(2'b00, 1'b1, 32'h55, 1'b0);
    stepCycle();
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("f4_pre_rst_flush", 32'(flush4), 32'h1);
    checkOutput("f4_pre_rst_pc", new_pc4, 32'h55);
    rst = 1'b0;
    #1;
    checkOutput("f4_rst_flush", 32'(flush4), 32'h0);
    checkOutput("f4_rst_pc", new_pc4, 32'h0);
    checkOutput("f4_rst_stall", 32'(stall4), 32'h0);
    waitSample();
    stepCycle();
    rst = 1'b1;
    applyStimulus(2'b00, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      waitSample();
      checkOutput($sformatf("f4_no_residual%0d", k), 32'(flush4), 32'h0);
      stepCycle();
    end
    applyStimulus(2'b01, 1'b0, 32'h0, 1'b0);
    stepCycle();
    stepCycle();
    waitSample();
    checkOutput("f4_after_rst_cycles", 32'(cycles4), 32'd1);
    checkOutput("f4_after_rst_stall", 32'(stall4), 32'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
